debounce_updown_counter: RTL and testbench
==========================================

Name: debounce_updown_counter

Overview:
- Multi-button successor to the single-button press counter.
- Three raw mechanical inputs (up, down, clear) are synchronised, digitally debounced and edge-detected, all in the auto_clk domain.
- The edges drive a wrap-around modulo up/down counter shown on one 7-segment digit (hex-capable).
- It sits between board push-buttons and the display pins, with no derived or gated clocks.

Parameters:
- DB_CYCLES, 3: consecutive auto_clk samples a synchronised input must differ from the accepted level before the new level is accepted (legal range 1..255).
- CNT_MAX, 9: highest count value; the counter runs 0..CNT_MAX and wraps (legal range 1..15).
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are active-low; 0 inverts all seven.

Ports:
- rst  input  1  asynchronous, active-high reset
- auto_clk  input  1  sampling/system clock; every flop in the block is on its rising edge
- btn_up  input  1  raw up button, asynchronous, bouncy
- btn_dn  input  1  raw down button, asynchronous, bouncy
- btn_clr  input  1  raw clear button, asynchronous, bouncy
- count  output  4  current counter value
- up_pulse  output  1  one-cycle strobe per accepted up press
- dn_pulse  output  1  one-cycle strobe per accepted down press
- a,b,c,d,e,f,g  output  1 each  segment drives for the count digit

Behaviour:
- Reset (async, rst high): all synchroniser flops, debounced levels and debounce counters go to 0.
  - count=0, up_pulse=0, dn_pulse=0.
  - Segments show "0" (active-low {a..g}=0000001).
  - Reset mid-bounce discards any partial debounce progress.
- Synchroniser: 2 flops per channel, giving s2.
- Debounce, per channel: accepted level db, counter dc of width ceil(log2(DB_CYCLES+1)).
  - If s2==db: dc<=0.
  - Else if dc==DB_CYCLES-1: db<=s2, dc<=0.
  - Else: dc<=dc+1.
  - Any sample matching db restarts the qualification, so glitches shorter than DB_CYCLES samples are ignored.
- Edge detect: rise = next-db high while db low. It is evaluated on the edge where db goes 0->1; only press (rising) edges act, release edges are ignored.
- Counter update on the same edge as db rises. Priority per edge:
  - clr rise: count<=0.
  - Else up rise and dn rise together: hold.
  - Else up rise: count<=(count==CNT_MAX)?0:count+1.
  - Else dn rise: count<=(count==0)?CNT_MAX:count-1.
- up_pulse/dn_pulse: registered, high for exactly one cycle following the db rise edge.
  - They assert even when the count holds because of simultaneity or clear.
  - Holding a button never re-pulses.
- Latency: a raw rising edge first sampled at edge k makes count change at edge k+1+DB_CYCLES, i.e. 2+DB_CYCLES edges after the raw change. The pulse is high during the cycle after that edge.
- Segment decode is combinational from count. Active-low {a..g} patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - SEG_ACTIVE_LOW=0 inverts every pattern.
- count never exceeds CNT_MAX (invariant, including immediately after reset).

Decomposition:
- Shared package holds:
  - the 16-entry active-low hex segment table as constants;
  - SEG_OFF=1111111.
- One sub-module, debounce_ch:
  - parameter DB_CYCLES;
  - ports rst, auto_clk, raw, level, rise;
  - contains the 2-flop synchroniser and the debounce counter;
  - instantiated three times.
- Counter, pulse registers and decoder stay in the top level.

Test Plan:
- Clean press, DB_CYCLES=3: btn_up rises before edge k and is held -> count 0->1 at edge k+4; up_pulse high for exactly 1 cycle; no further change while held.
- Bounce: btn_up toggles 1,0,1,0 each cycle then holds 1 -> exactly one increment; no increment for any glitch of 1-2 cycles.
- Wrap, CNT_MAX=9: 9 ups from 0 -> count=9 and {a..g}=0000100; a 10th up -> count=0. One down from 0 -> count=9.
- Simultaneity: up and dn rise on the same cycle at count=4 -> count stays 4, both pulses fire. clr and up rise together at count=7 -> count=0.
- Async reset mid-operation: assert rst during debounce qualification at count=5 -> count=0 and segments 0000001 immediately; after release, a held button counts once after a full 2+DB_CYCLES edges.
- Hex/polarity: CNT_MAX=15, SEG_ACTIVE_LOW=0, step to count=11 -> {a..g}=0011111 ("b" inverted).

Source files
------------

// File: rtl/debounce_updown_counter_pkg.sv
// Purpose: shared constants for the debounced up/down counter (segment table, helpers).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package debounce_updown_counter_pkg;

  // Active-low {a..g}; all segments dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low {a..g} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] v);
    return SEG_HEX[v];
  endfunction

  // Debounce counter width able to hold 0..n.
  function automatic int dc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// Purpose: one button channel: 2-flop synchroniser, digital debounce, press-edge detect.
// Latency: a raw change reaches 'level' 1+DB_CYCLES edges after it is first sampled.
// Backpressure: none; free-running sampler.
// Ports: rst (async, active-high), auto_clk, raw (bouncy async input),
//        level (accepted debounced level), rise (high while level is about to go 0->1).
module debounce_ch
  import debounce_updown_counter_pkg::*;
#(
  parameter int DB_CYCLES = 3
) (
  input  logic rst,
  input  logic auto_clk,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int              DCW     = dc_width(DB_CYCLES);
  localparam logic [DCW-1:0]  DC_LAST = DCW'(DB_CYCLES - 1);

  logic           s1_q, s2_q;
  logic           db_q, db_d;
  logic [DCW-1:0] dc_q, dc_d;

  always_ff @(posedge auto_clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      dc_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      db_q <= db_d;
      dc_q <= dc_d;
    end
  end

  // A sample that agrees with the accepted level restarts qualification,
  // so only DB_CYCLES consecutive disagreeing samples flip the level.
  always_comb begin
    db_d = db_q;
    dc_d = dc_q;
    if (s2_q == db_q) begin
      dc_d = '0;
    end else if (dc_q == DC_LAST) begin
      db_d = s2_q;
      dc_d = '0;
    end else begin
      dc_d = dc_q + DCW'(1);
    end
  end

  assign level = db_q;
  assign rise  = db_d & ~db_q;

endmodule

// File: rtl/debounce_updown_counter.sv
// Purpose: three debounced buttons drive a wrap-around 0..CNT_MAX counter shown on one 7-seg digit.
// Latency: count moves 2+DB_CYCLES edges after a raw press; pulses high the cycle after.
// Backpressure: none; every accepted press edge acts immediately.
// Ports: rst (async, active-high), auto_clk, btn_up/btn_dn/btn_clr (raw buttons),
//        count (current value), up_pulse/dn_pulse (one-cycle press strobes), a..g (segments).
module debounce_updown_counter
  import debounce_updown_counter_pkg::*;
#(
  parameter int DB_CYCLES      = 3,
  parameter int CNT_MAX        = 9,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       rst,
  input  logic       auto_clk,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_clr,
  output logic [3:0] count,
  output logic       up_pulse,
  output logic       dn_pulse,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [3:0] CNT_TOP = 4'(CNT_MAX);

  logic up_lvl, dn_lvl, clr_lvl;
  logic up_rise, dn_rise, clr_rise;

  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_up (
    .rst(rst), .auto_clk(auto_clk), .raw(btn_up),  .level(up_lvl),  .rise(up_rise)
  );
  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_dn (
    .rst(rst), .auto_clk(auto_clk), .raw(btn_dn),  .level(dn_lvl),  .rise(dn_rise)
  );
  debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .rst(rst), .auto_clk(auto_clk), .raw(btn_clr), .level(clr_lvl), .rise(clr_rise)
  );

  logic [3:0] count_q, count_d;
  logic       up_pulse_q, up_pulse_d;
  logic       dn_pulse_q, dn_pulse_d;

  always_ff @(posedge auto_clk or posedge rst) begin
    if (rst) begin
      count_q    <= 4'd0;
      up_pulse_q <= 1'b0;
      dn_pulse_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      up_pulse_q <= up_pulse_d;
      dn_pulse_q <= dn_pulse_d;
    end
  end

  // Clear wins; simultaneous up+down cancel; otherwise step with wrap.
  always_comb begin
    count_d    = count_q;
    up_pulse_d = up_rise;
    dn_pulse_d = dn_rise;
    if (clr_rise) begin
      count_d = 4'd0;
    end else if (up_rise && dn_rise) begin
      count_d = count_q;
    end else if (up_rise) begin
      count_d = (count_q == CNT_TOP) ? 4'd0 : count_q + 4'd1;
    end else if (dn_rise) begin
      count_d = (count_q == 4'd0) ? CNT_TOP : count_q - 4'd1;
    end
  end

  logic [6:0] seg_al, seg;

  always_comb begin
    seg_al = seg_lookup(count_q);
    seg    = (SEG_ACTIVE_LOW != 0) ? seg_al : (seg_al ^ SEG_OFF);
  end

  assign {a, b, c, d, e, f, g} = seg;
  assign count    = count_q;
  assign up_pulse = up_pulse_q;
  assign dn_pulse = dn_pulse_q;

  // A rise is only ever seen from a low accepted level, and a strobe
  // always coincides with the freshly accepted high level.
  a_up_rise_from_low:  assert property (@(posedge auto_clk) disable iff (rst) up_rise  |-> !up_lvl);
  a_dn_rise_from_low:  assert property (@(posedge auto_clk) disable iff (rst) dn_rise  |-> !dn_lvl);
  a_clr_rise_from_low: assert property (@(posedge auto_clk) disable iff (rst) clr_rise |-> !clr_lvl);
  a_up_pulse_level:    assert property (@(posedge auto_clk) disable iff (rst) up_pulse_q |-> up_lvl);
  a_dn_pulse_level:    assert property (@(posedge auto_clk) disable iff (rst) dn_pulse_q |-> dn_lvl);
  a_count_in_range:    assert property (@(posedge auto_clk) count_q <= CNT_TOP);

endmodule

// File: tb/tb_debounce_updown_counter.sv
// Purpose: directed bench for the debounced up/down counter (default and hex/inverted builds).
// Latency: checks exact press-to-count latency of 2+DB_CYCLES edges.
// Backpressure: n/a.
module tb_debounce_updown_counter;

  logic       rst, auto_clk;
  logic       btn_up, btn_dn, btn_clr;
  logic [3:0] count, count_h;
  logic       up_pulse, dn_pulse, up_pulse_h, dn_pulse_h;
  logic       a, b, c, d, e, f, g;
  logic       ha, hb, hc, hd, he, hf, hg;
  logic [6:0] seg, seg_h;

  assign seg   = {a, b, c, d, e, f, g};
  assign seg_h = {ha, hb, hc, hd, he, hf, hg};

  debounce_updown_counter dut (
    .rst(rst), .auto_clk(auto_clk),
    .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .count(count), .up_pulse(up_pulse), .dn_pulse(dn_pulse),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  debounce_updown_counter #(.DB_CYCLES(3), .CNT_MAX(15), .SEG_ACTIVE_LOW(0)) dut_hex (
    .rst(rst), .auto_clk(auto_clk),
    .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .count(count_h), .up_pulse(up_pulse_h), .dn_pulse(dn_pulse_h),
    .a(ha), .b(hb), .c(hc), .d(hd), .e(he), .f(hf), .g(hg)
  );

  initial auto_clk = 1'b0;
  always #5 auto_clk = ~auto_clk;

  typedef struct {
    logic       up;
    logic       dn;
    logic       clr;
    logic [3:0] cnt;
    int         nup;
    int         ndn;
    logic [6:0] seg;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_miss   = 0;
  int   pu, pd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic u, input logic dd, input logic cl, input logic [3:0] cn,
                     input int nu, input int nd, input logic [6:0] sg);
    vec_t v;
    v.up = u; v.dn = dd; v.clr = cl; v.cnt = cn; v.nup = nu; v.ndn = nd; v.seg = sg;
    vq.push_back(v);
  endtask

  task automatic tick(inout int nu, inout int nd);
    @(negedge auto_clk);
    if (up_pulse === 1'b1) nu++;
    if (dn_pulse === 1'b1) nd++;
  endtask

  // Hold the chosen buttons long enough to be accepted, then release and settle.
  task automatic press(input logic u, input logic dd, input logic cl, output int nu, output int nd);
    int lu, ld;
    lu = 0; ld = 0;
    btn_up = u; btn_dn = dd; btn_clr = cl;
    repeat (8) tick(lu, ld);
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    repeat (8) tick(lu, ld);
    nu = lu; nd = ld;
  endtask

  task automatic do_reset();
    @(negedge auto_clk);
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    rst = 1'b1;
    @(negedge auto_clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;

    add(1,0,0, 4'd1, 1,0, 7'b1001111);
    add(1,0,0, 4'd2, 1,0, 7'b0010010);
    add(1,0,0, 4'd3, 1,0, 7'b0000110);
    add(1,0,0, 4'd4, 1,0, 7'b1001100);
    add(1,0,0, 4'd5, 1,0, 7'b0100100);
    add(1,0,0, 4'd6, 1,0, 7'b0100000);
    add(1,0,0, 4'd7, 1,0, 7'b0001111);
    add(1,0,0, 4'd8, 1,0, 7'b0000000);
    add(1,0,0, 4'd9, 1,0, 7'b0000100);
    add(1,0,0, 4'd0, 1,0, 7'b0000001);
    add(0,1,0, 4'd9, 0,1, 7'b0000100);
    add(0,1,0, 4'd8, 0,1, 7'b0000000);
    add(0,1,0, 4'd7, 0,1, 7'b0001111);
    add(1,0,1, 4'd0, 1,0, 7'b0000001);
    add(1,0,0, 4'd1, 1,0, 7'b1001111);
    add(1,0,0, 4'd2, 1,0, 7'b0010010);
    add(1,0,0, 4'd3, 1,0, 7'b0000110);
    add(1,0,0, 4'd4, 1,0, 7'b1001100);
    add(1,1,0, 4'd4, 1,1, 7'b1001100);
    add(0,0,1, 4'd0, 0,0, 7'b0000001);
    add(0,1,0, 4'd9, 0,1, 7'b0000100);

    // Reset state
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_seg", 32'(seg), 32'b0000001);
    chk("reset_up_pulse", 32'(up_pulse), 32'd0);
    chk("reset_dn_pulse", 32'(dn_pulse), 32'd0);
    @(negedge auto_clk);
    @(negedge auto_clk);
    rst = 1'b0;

    // Table-driven presses
    for (int i = 0; i < vq.size(); i++) begin
      press(vq[i].up, vq[i].dn, vq[i].clr, pu, pd);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vq[i].seg));
      chk($sformatf("vec%0d_up_pulses", i), 32'(pu), 32'(vq[i].nup));
      chk($sformatf("vec%0d_dn_pulses", i), 32'(pd), 32'(vq[i].ndn));
    end

    // Clean press: exact latency and single strobe
    do_reset();
    pu = 0; pd = 0;
    btn_up = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(pu, pd);
      chk($sformatf("latency_hold_edge%0d", i), 32'(count), 32'd0);
    end
    tick(pu, pd);
    chk("latency_count_step", 32'(count), 32'd1);
    chk("latency_up_pulse_high", 32'(up_pulse), 32'd1);
    tick(pu, pd);
    chk("latency_up_pulse_low", 32'(up_pulse), 32'd0);
    repeat (10) tick(pu, pd);
    chk("held_no_repeat_count", 32'(count), 32'd1);
    chk("held_no_repeat_pulses", 32'(pu), 32'd1);
    btn_up = 1'b0;
    repeat (8) tick(pu, pd);

    // Bounce: 1,0,1,0 then held
    pu = 0; pd = 0;
    btn_up = 1'b1; tick(pu, pd);
    btn_up = 1'b0; tick(pu, pd);
    btn_up = 1'b1; tick(pu, pd);
    btn_up = 1'b0; tick(pu, pd);
    btn_up = 1'b1;
    repeat (10) tick(pu, pd);
    btn_up = 1'b0;
    repeat (8) tick(pu, pd);
    chk("bounce_count", 32'(count), 32'd2);
    chk("bounce_pulses", 32'(pu), 32'd1);

    // Short glitches are ignored
    pu = 0; pd = 0;
    btn_up = 1'b1; tick(pu, pd);
    btn_up = 1'b0; repeat (8) tick(pu, pd);
    chk("glitch1_count", 32'(count), 32'd2);
    btn_up = 1'b1; tick(pu, pd); tick(pu, pd);
    btn_up = 1'b0; repeat (8) tick(pu, pd);
    chk("glitch2_count", 32'(count), 32'd2);
    chk("glitch_pulses", 32'(pu), 32'd0);

    // Async reset mid-qualification at count 5
    repeat (3) press(1'b1, 1'b0, 1'b0, pu, pd);
    chk("pre_reset_count", 32'(count), 32'd5);
    @(negedge auto_clk);
    btn_up = 1'b1;
    @(negedge auto_clk);
    @(negedge auto_clk);
    @(negedge auto_clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_seg", 32'(seg), 32'b0000001);
    @(negedge auto_clk);
    rst = 1'b0;
    pu = 0; pd = 0;
    for (int i = 1; i <= 4; i++) begin
      tick(pu, pd);
      chk($sformatf("post_reset_hold_edge%0d", i), 32'(count), 32'd0);
    end
    tick(pu, pd);
    chk("post_reset_count_step", 32'(count), 32'd1);
    repeat (10) tick(pu, pd);
    chk("post_reset_held_count", 32'(count), 32'd1);
    chk("post_reset_pulses", 32'(pu), 32'd1);
    btn_up = 1'b0;
    repeat (8) tick(pu, pd);

    // Hex digit with inverted segment polarity
    do_reset();
    for (int i = 0; i < 11; i++) press(1'b1, 1'b0, 1'b0, pu, pd);
    chk("hex_count", 32'(count_h), 32'd11);
    chk("hex_seg_inverted_b", 32'(seg_h), 32'b0011111);
    chk("dec_wrapped_count", 32'(count), 32'd1);
    chk("dec_wrapped_seg", 32'(seg), 32'b1001111);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
